// File: rtl/snes_bus_responder.sv
// SNES bus-cycle responder: synchronises /RD and /WR and runs one SRAM request per cycle.
// Optional per-direction ack counters are enabled with `define SNES_RESP_STATS_EN.
module snes_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 32,
    parameter logic [7:0]  OPEN_BUS_VAL   = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_RD_N,
    input  logic        SNES_WR_N,
    input  logic [23:0] ROM_ADDR,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic [7:0]  SNES_DATA_IN,
    output logic [7:0]  SNES_DATA_OUT,
    output logic        SNES_DATA_OE,
    output logic [23:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    output logic        MEM_RD_REQ,
    output logic        MEM_WR_REQ,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    output logic        BUSY,
`ifdef SNES_RESP_STATS_EN
    output logic        TIMEOUT_ERR,
    output logic [15:0] STAT_RD_CNT,
    output logic [15:0] STAT_WR_CNT
`else
    output logic        TIMEOUT_ERR
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_HOLD = 3'd2,
        ST_WR_ARM  = 3'd3,
        ST_WR_WAIT = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]  rd_sync_q;
    logic [2:0]  wr_sync_q;
    logic        rd_fall_d, rd_rise_d, wr_fall_d, wr_rise_d;
    logic        rd_fall_q, rd_rise_q, wr_fall_q, wr_rise_q;
    logic        rd_still_low_d;

    state_t      state_q;
    logic [7:0]  tmo_cnt_q;
    logic        rd_active_q;
    logic        wr_qual_q;
    logic [7:0]  data_out_q;
    logic        oe_q;
    logic [23:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        rd_req_q;
    logic        wr_req_q;
    logic        busy_q;
    logic        tmo_err_q;

    // Edges are taken between stages 2 and 3, then registered into one-cycle pulses.
    assign rd_fall_d = rd_sync_q[2] & ~rd_sync_q[1];
    assign rd_rise_d = ~rd_sync_q[2] & rd_sync_q[1];
    assign wr_fall_d = wr_sync_q[2] & ~wr_sync_q[1];
    assign wr_rise_d = ~wr_sync_q[2] & wr_sync_q[1];

    // A read counts as still in progress until its synced rising edge is seen.
    assign rd_still_low_d = rd_active_q & ~rd_rise_q;

    // Strobe synchronisers and edge pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_sync_q <= 3'b111;
            wr_sync_q <= 3'b111;
            rd_fall_q <= 1'b0;
            rd_rise_q <= 1'b0;
            wr_fall_q <= 1'b0;
            wr_rise_q <= 1'b0;
        end else begin
            rd_sync_q <= {rd_sync_q[1:0], SNES_RD_N};
            wr_sync_q <= {wr_sync_q[1:0], SNES_WR_N};
            rd_fall_q <= rd_fall_d;
            rd_rise_q <= rd_rise_d;
            wr_fall_q <= wr_fall_d;
            wr_rise_q <= wr_rise_d;
        end
    end

    // Bus-cycle FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= 8'd0;
            rd_active_q <= 1'b0;
            wr_qual_q   <= 1'b0;
            data_out_q  <= 8'h00;
            oe_q        <= 1'b0;
            mem_addr_q  <= 24'h000000;
            mem_wdata_q <= 8'h00;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A simultaneous write edge loses to the read edge.
                    if (rd_fall_q) begin
                        if (ROM_HIT) begin
                            mem_addr_q  <= ROM_ADDR;
                            rd_req_q    <= 1'b1;
                            tmo_cnt_q   <= 8'd0;
                            rd_active_q <= 1'b1;
                            busy_q      <= 1'b1;
                            state_q     <= ST_RD_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (wr_fall_q) begin
                        mem_addr_q <= ROM_ADDR;
                        wr_qual_q  <= IS_WRITABLE & ROM_HIT;
                        busy_q     <= 1'b1;
                        state_q    <= ST_WR_ARM;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RD_WAIT: begin
                    if (MEM_ACK) begin
                        rd_req_q    <= 1'b0;
                        rd_active_q <= 1'b0;
                        if (rd_still_low_d) begin
                            data_out_q <= MEM_RDATA;
                            oe_q       <= 1'b1;
                            state_q    <= ST_RD_HOLD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rd_req_q    <= 1'b0;
                        rd_active_q <= 1'b0;
                        tmo_err_q   <= 1'b1;
                        if (rd_still_low_d) begin
                            data_out_q <= OPEN_BUS_VAL;
                            oe_q       <= 1'b1;
                            state_q    <= ST_RD_HOLD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + 8'd1;
                        rd_active_q <= rd_still_low_d;
                    end
                end

                ST_RD_HOLD: begin
                    if (rd_rise_q) begin
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RD_HOLD;
                    end
                end

                ST_WR_ARM: begin
                    if (wr_rise_q) begin
                        if (wr_qual_q) begin
                            mem_wdata_q <= SNES_DATA_IN;
                            wr_req_q    <= 1'b1;
                            tmo_cnt_q   <= 8'd0;
                            state_q     <= ST_WR_WAIT;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_WR_ARM;
                    end
                end

                ST_WR_WAIT: begin
                    if (MEM_ACK) begin
                        wr_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        wr_req_q  <= 1'b0;
                        tmo_err_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end

                default: begin
                    rd_req_q    <= 1'b0;
                    wr_req_q    <= 1'b0;
                    oe_q        <= 1'b0;
                    rd_active_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SNES_RESP_STATS_EN
    logic [15:0] stat_rd_q;
    logic [15:0] stat_wr_q;

    // Count acks that were actually accepted; both wrap naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_rd_q <= 16'h0000;
            stat_wr_q <= 16'h0000;
        end else begin
            if ((state_q == ST_RD_WAIT) && MEM_ACK) begin
                stat_rd_q <= stat_rd_q + 16'h0001;
            end else begin
                stat_rd_q <= stat_rd_q;
            end
            if ((state_q == ST_WR_WAIT) && MEM_ACK) begin
                stat_wr_q <= stat_wr_q + 16'h0001;
            end else begin
                stat_wr_q <= stat_wr_q;
            end
        end
    end

    assign STAT_RD_CNT = stat_rd_q;
    assign STAT_WR_CNT = stat_wr_q;
`endif

    assign SNES_DATA_OUT = data_out_q;
    assign SNES_DATA_OE  = oe_q;
    assign MEM_ADDR      = mem_addr_q;
    assign MEM_WDATA     = mem_wdata_q;
    assign MEM_RD_REQ    = rd_req_q;
    assign MEM_WR_REQ    = wr_req_q;
    assign BUSY          = busy_q;
    assign TIMEOUT_ERR   = tmo_err_q;

endmodule

// File: tb/tb_snes_bus_responder.sv
// Randomised bench for snes_bus_responder: transactions are scored against outcomes
// derived from the bus rules (latencies, ack-vs-timeout, sticky error).
module tb_snes_bus_responder;

    localparam int TMO = 32;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SNES_RD_N, SNES_WR_N;
    logic [23:0] ROM_ADDR;
    logic        ROM_HIT, IS_WRITABLE;
    logic [7:0]  SNES_DATA_IN;
    logic [7:0]  SNES_DATA_OUT;
    logic        SNES_DATA_OE;
    logic [23:0] MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic        MEM_RD_REQ, MEM_WR_REQ;
    logic        MEM_ACK;
    logic [7:0]  MEM_RDATA;
    logic        BUSY, TIMEOUT_ERR;
`ifdef SNES_RESP_STATS_EN
    logic [15:0] STAT_RD_CNT, STAT_WR_CNT;
`endif

    always #5 CLK = ~CLK;

    snes_bus_responder #(.TIMEOUT_CYCLES(TMO), .OPEN_BUS_VAL(8'hFF)) dut (
        .CLK(CLK), .RST(RST),
        .SNES_RD_N(SNES_RD_N), .SNES_WR_N(SNES_WR_N),
        .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT), .IS_WRITABLE(IS_WRITABLE),
        .SNES_DATA_IN(SNES_DATA_IN), .SNES_DATA_OUT(SNES_DATA_OUT), .SNES_DATA_OE(SNES_DATA_OE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RD_REQ(MEM_RD_REQ), .MEM_WR_REQ(MEM_WR_REQ),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUSY(BUSY),
`ifdef SNES_RESP_STATS_EN
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .STAT_RD_CNT(STAT_RD_CNT), .STAT_WR_CNT(STAT_WR_CNT)
`else
        .TIMEOUT_ERR(TIMEOUT_ERR)
`endif
    );

    int n_vectors = 0;
    int n_miscompares = 0;
    bit exp_err = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Read cycle; delay = index of the requesting cycle that carries MEM_ACK (>= TMO: none).
    task automatic do_read(input logic [23:0] addr, input logic [7:0] data, input int delay,
                           input bit abort_rd);
        int n;
        int hi;
        int exp_hi;
        ROM_ADDR = addr; ROM_HIT = 1'b1; IS_WRITABLE = 1'($urandom_range(0, 1)); SNES_RD_N = 1'b0;
        n = 0;
        while (MEM_RD_REQ !== 1'b1 && n < 20) begin tick(); n++; end
        check_value("rd_req_latency", 32'(n), 32'd4);
        ROM_ADDR = 24'($urandom);
        check_value("rd_addr", 32'(MEM_ADDR), 32'(addr));
        if (abort_rd) begin
            SNES_RD_N = 1'b1;
            repeat (5) tick();
            MEM_ACK = 1'b1; MEM_RDATA = data;
            tick();
            MEM_ACK = 1'b0;
            check_value("abort_req_drop", 32'(MEM_RD_REQ), 32'd0);
            hi = 0;
            repeat (4) begin
                if (SNES_DATA_OE !== 1'b0 || BUSY !== 1'b0) hi++;
                tick();
            end
            check_value("abort_oe_busy", 32'(hi), 32'd0);
        end else begin
            hi = 0;
            while (MEM_RD_REQ === 1'b1 && hi < 100) begin
                if (hi == delay) begin MEM_ACK = 1'b1; MEM_RDATA = data; end
                if (MEM_ADDR !== addr) check_value("rd_addr_stable", 32'(MEM_ADDR), 32'(addr));
                tick();
                MEM_ACK = 1'b0;
                hi++;
            end
            exp_hi = (delay < TMO) ? delay + 1 : TMO;
            if (delay >= TMO) exp_err = 1'b1;
            check_value("rd_req_cycles", 32'(hi), 32'(exp_hi));
            check_value("rd_oe", 32'(SNES_DATA_OE), 32'd1);
            check_value("rd_data", 32'(SNES_DATA_OUT), (delay < TMO) ? 32'(data) : 32'hFF);
            check_value("rd_busy_hold", 32'(BUSY), 32'd1);
            check_value("rd_tmo_err", 32'(TIMEOUT_ERR), 32'(exp_err));
            SNES_RD_N = 1'b1;
            n = 0;
            while (SNES_DATA_OE === 1'b1 && n < 20) begin tick(); n++; end
            check_value("rd_oe_release", 32'(n), 32'd4);
            check_value("rd_busy_done", 32'(BUSY), 32'd0);
        end
        MEM_RDATA = 8'($urandom);
        repeat (2) tick();
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [7:0] data, input bit writable,
                            input bit hit, input int delay);
        int n;
        int hi;
        int exp_hi;
        ROM_ADDR = addr; IS_WRITABLE = writable; ROM_HIT = hit;
        SNES_DATA_IN = 8'($urandom); SNES_WR_N = 1'b0;
        repeat (6) tick();
        check_value("wr_arm_busy", 32'(BUSY), 32'd1);
        check_value("wr_arm_noreq", 32'(MEM_WR_REQ), 32'd0);
        ROM_ADDR = ~addr; IS_WRITABLE = 1'($urandom_range(0, 1)); ROM_HIT = 1'($urandom_range(0, 1));
        SNES_DATA_IN = data; SNES_WR_N = 1'b1;
        if (writable && hit) begin
            n = 0;
            while (MEM_WR_REQ !== 1'b1 && n < 20) begin tick(); n++; end
            check_value("wr_req_latency", 32'(n), 32'd4);
            check_value("wr_addr", 32'(MEM_ADDR), 32'(addr));
            check_value("wr_data", 32'(MEM_WDATA), 32'(data));
            SNES_DATA_IN = 8'($urandom);
            hi = 0;
            while (MEM_WR_REQ === 1'b1 && hi < 100) begin
                if (hi == delay) MEM_ACK = 1'b1;
                if (MEM_WDATA !== data) check_value("wr_data_stable", 32'(MEM_WDATA), 32'(data));
                tick();
                MEM_ACK = 1'b0;
                hi++;
            end
            exp_hi = (delay < TMO) ? delay + 1 : TMO;
            if (delay >= TMO) exp_err = 1'b1;
            check_value("wr_req_cycles", 32'(hi), 32'(exp_hi));
            check_value("wr_busy_done", 32'(BUSY), 32'd0);
            check_value("wr_tmo_err", 32'(TIMEOUT_ERR), 32'(exp_err));
        end else begin
            hi = 0;
            repeat (8) begin tick(); if (MEM_WR_REQ !== 1'b0) hi++; end
            check_value("wr_unqual_noreq", 32'(hi), 32'd0);
            check_value("wr_unqual_busy", 32'(BUSY), 32'd0);
        end
        repeat (2) tick();
    endtask

    task automatic do_read_miss(input logic [23:0] addr);
        int hi;
        ROM_ADDR = addr; ROM_HIT = 1'b0; SNES_RD_N = 1'b0;
        hi = 0;
        repeat (8) begin tick(); if (MEM_RD_REQ || SNES_DATA_OE || BUSY) hi++; end
        check_value("rd_miss_ignored", 32'(hi), 32'd0);
        SNES_RD_N = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int kind;
        RST = 1'b1; SNES_RD_N = 1'b1; SNES_WR_N = 1'b1;
        ROM_ADDR = 24'h0; ROM_HIT = 1'b0; IS_WRITABLE = 1'b0;
        SNES_DATA_IN = 8'h00; MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
        repeat (3) tick();
        check_value("rst_outputs", {SNES_DATA_OUT, 7'd0, SNES_DATA_OE, MEM_RD_REQ, MEM_WR_REQ,
                                    BUSY, TIMEOUT_ERR, MEM_WDATA}, 32'd0);
        check_value("rst_addr", 32'(MEM_ADDR), 32'd0);
        RST = 1'b0;
        repeat (2) tick();

        do_read(24'h123456, 8'hA5, 3, 1'b0);
        do_write(24'hE00010, 8'h3C, 1'b1, 1'b1, 2);
        do_write(24'hE00011, 8'h55, 1'b0, 1'b1, 0);
        do_read(24'h00ABCD, 8'h11, TMO + 8, 1'b0);
        do_read(24'h200000, 8'h77, 0, 1'b1);
        do_read(24'h200001, 8'h5C, 1, 1'b0);
        do_read(24'h200002, 8'h9E, TMO - 1, 1'b0);
        do_write(24'hE00020, 8'hC3, 1'b1, 1'b1, TMO + 2);

        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: do_read(24'($urandom), 8'($urandom),
                           ($urandom_range(0, 9) == 0) ? TMO + 3 : $urandom_range(0, 8), 1'b0);
                1: do_read(24'($urandom), 8'($urandom), 0, 1'b1);
                2: do_write(24'($urandom), 8'($urandom), 1'b1, 1'b1, $urandom_range(0, 8));
                3: do_write(24'($urandom), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0);
                default: do_read_miss(24'($urandom));
            endcase
        end

        // Simultaneous strobes: the read wins and no write follows.
        ROM_ADDR = 24'h654321; ROM_HIT = 1'b1; IS_WRITABLE = 1'b1; SNES_DATA_IN = 8'hEE;
        SNES_RD_N = 1'b0; SNES_WR_N = 1'b0;
        n = 0;
        while (MEM_RD_REQ !== 1'b1 && n < 20) begin tick(); n++; end
        check_value("both_rd_latency", 32'(n), 32'd4);
        MEM_ACK = 1'b1; MEM_RDATA = 8'h42;
        tick();
        MEM_ACK = 1'b0;
        check_value("both_rd_data", 32'(SNES_DATA_OUT), 32'h42);
        SNES_RD_N = 1'b1; SNES_WR_N = 1'b1;
        hi = 0;
        repeat (10) begin tick(); if (MEM_WR_REQ !== 1'b0) hi++; end
        check_value("both_no_write", 32'(hi), 32'd0);
        check_value("both_idle", 32'(BUSY), 32'd0);

        // Reset mid-request, then an orphaned ack.
        ROM_ADDR = 24'h0F0F0F; SNES_RD_N = 1'b0;
        n = 0;
        while (MEM_RD_REQ !== 1'b1 && n < 20) begin tick(); n++; end
        check_value("rst_pre_req", 32'(MEM_RD_REQ), 32'd1);
        RST = 1'b1; SNES_RD_N = 1'b1;
        tick();
        exp_err = 1'b0;
        check_value("rst_mid_drop", {28'd0, MEM_RD_REQ, SNES_DATA_OE, BUSY, TIMEOUT_ERR}, 32'd0);
        RST = 1'b0;
        tick();
        MEM_ACK = 1'b1; MEM_RDATA = 8'h5A;
        tick();
        MEM_ACK = 1'b0;
        hi = 0;
        repeat (4) begin
            if (MEM_RD_REQ || MEM_WR_REQ || SNES_DATA_OE || BUSY || TIMEOUT_ERR) hi++;
            tick();
        end
        check_value("orphan_ack_quiet", 32'(hi), 32'd0);
        check_value("orphan_ack_data", 32'(SNES_DATA_OUT), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
